// File: rtl/counter_bcd_display.sv
// counter_bcd_display: serial double-dabble binary-to-BCD converter feeding a
// time-multiplexed, active-low 3-digit seven-segment display with leading-zero blanking.
module counter_bcd_display #(
  parameter int REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value_in,
  input  logic        load,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [19:0] scr, scr_adj, scr_shl;
  logic [2:0] cnt;
  logic last;
  assign last = cnt == 3'd7;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (load ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  always_comb
    busy = state == SHIFT;
  // scratch is {hundreds, tens, units, binary}; adjust BCD nibbles before each shift
  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < 3; i++)
      if (scr[8+4*i +: 4] >= 4'd5) scr_adj[8+4*i +: 4] = scr[8+4*i +: 4] + 4'd3;
    scr_shl = scr_adj << 1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scr     <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= state == SHIFT && last;
      if (state == IDLE && load) begin
        scr <= {12'h000, value_in};
        cnt <= '0;
      end else if (state == SHIFT) begin
        scr <= scr_shl;
        cnt <= cnt + 3'd1;
        if (last) bcd_out <= scr_shl[19:8];
      end
    end
  logic [15:0] div;
  logic [1:0] sel, sel_nxt;
  logic wrap;
  logic [3:0] hun, ten, unt;
  logic [6:0] seg_nxt;
  assign wrap = div == 16'(REFRESH_DIV - 1);
  assign sel_nxt = wrap ? (sel == 2'd2 ? 2'd0 : sel + 2'd1) : sel;
  assign {hun, ten, unt} = bcd_out;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  // anode and segments are registered from the upcoming select so they switch together
  always_comb
    seg_nxt = sel_nxt == 2'd0 ? seg7(unt) :
              sel_nxt == 2'd1 ? (hun == 4'd0 && ten == 4'd0 ? 7'h7F : seg7(ten)) :
                                (hun == 4'd0 ? 7'h7F : seg7(hun));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div   <= '0;
      sel   <= '0;
      an_n  <= 3'b110;
      seg_n <= 7'h40;
    end else begin
      div   <= wrap ? 16'd0 : div + 16'd1;
      sel   <= sel_nxt;
      an_n  <= ~(3'b001 << sel_nxt);
      seg_n <= seg_nxt;
    end
endmodule

// File: tb/tb_counter_bcd_display.sv
// tb_counter_bcd_display: table vectors, full sweep and random conversions against an
// arithmetic decimal model, plus reset, collision, back-to-back and display-mux sequences.
module tb_counter_bcd_display;
  localparam int RD = 4;
  logic clk = 1'b0, rst, load, busy, valid;
  logic [7:0] value_in;
  logic [11:0] bcd_out;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  int checks = 0, errors = 0;
  counter_bcd_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .busy(busy),
    .valid(valid), .bcd_out(bcd_out), .seg_n(seg_n), .an_n(an_n)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] v; logic [11:0] exp;} vec_t;
  vec_t tbl[12];
  logic [6:0] segs[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [6:0] ref_seg(input int v, input int d);
    int p = d == 0 ? 1 : d == 1 ? 10 : 100;
    if (d > 0 && v < p) return 7'h7F;
    return segs[(v / p) % 10];
  endfunction
  task automatic conv(input logic [7:0] v, output int lat);
    int bb = 0;
    @(negedge clk);
    value_in = v;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy_after_load", busy, 1);
    lat = 0;
    while (lat < 20 && !valid) begin
      @(posedge clk); #1;
      lat++;
      if (busy !== (lat < 8)) bb++;
      value_in = 8'($urandom);
    end
    chk("latency", lat, 8);
    chk("busy_window", bb, 0);
    @(posedge clk); #1;
    chk("valid_pulse", valid, 0);
  endtask
  task automatic mux_check(input int v);
    logic [2:0] prev, an_exp;
    int k;
    prev = an_n;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (an_n == 3'b110 && prev != 3'b110) break;
      prev = an_n;
    end
    chk("mux_sync", k < 20, 1);
    for (int j = 0; j < 3 * RD; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      an_exp = ~(3'b001 << (j / RD));
      chk("mux_an", an_n, an_exp);
      chk("mux_seg", seg_n, ref_seg(v, j / RD));
    end
  endtask
  initial begin
    int lat, nv, first, second;
    tbl = '{'{8'd0, 12'h000}, '{8'd1, 12'h001}, '{8'd9, 12'h009}, '{8'd10, 12'h010},
            '{8'd5, 12'h005}, '{8'd50, 12'h050}, '{8'd99, 12'h099}, '{8'd100, 12'h100},
            '{8'd128, 12'h128}, '{8'd199, 12'h199}, '{8'd200, 12'h200}, '{8'd255, 12'h255}};
    rst = 1'b1; load = 1'b0; value_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd_out, 12'h000);
    chk("rst_an", an_n, 3'b110);
    chk("rst_seg", seg_n, 7'h40);
    conv(8'd255, lat);
    chk("conv_255", bcd_out, 12'h255);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_valid", valid, 0);
    chk("async_bcd", bcd_out, 12'h000);
    chk("async_an", an_n, 3'b110);
    chk("async_seg", seg_n, 7'h40);
    repeat (3) @(posedge clk); #1;
    chk("hold_bcd", bcd_out, 12'h000);
    chk("hold_an", an_n, 3'b110);
    chk("hold_seg", seg_n, 7'h40);
    @(negedge clk) rst = 1'b0;
    foreach (tbl[i]) begin
      conv(tbl[i].v, lat);
      chk("table", bcd_out, tbl[i].exp);
    end
    for (int i = 0; i < 256; i++) begin
      conv(8'(i), lat);
      chk("sweep", bcd_out, ref_bcd(i));
    end
    repeat (30) begin
      nv = int'($urandom_range(0, 255));
      conv(8'(nv), lat);
      chk("random", bcd_out, ref_bcd(nv));
    end
    @(negedge clk); value_in = 8'd100; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    value_in = 8'd7; load = 1'b1;
    @(negedge clk); load = 1'b0;
    nv = 0;
    repeat (15) begin @(posedge clk); #1; if (valid) nv++; end
    chk("collide_valids", nv, 1);
    chk("collide_bcd", bcd_out, 12'h100);
    conv(8'd7, lat);
    chk("after_collide", bcd_out, 12'h007);
    mux_check(7);
    conv(8'd100, lat);
    mux_check(100);
    conv(8'd200, lat);
    @(negedge clk); value_in = 8'd200; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (12) begin @(posedge clk); #1; if (valid) nv++; end
    chk("midrst_valids", nv, 0);
    chk("midrst_bcd", bcd_out, 12'h000);
    @(negedge clk) rst = 1'b0;
    conv(8'd200, lat);
    chk("midrst_reconv", bcd_out, 12'h200);
    @(negedge clk); value_in = 8'd42; load = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 30 && second < 0; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (first < 0) first = c; else second = c;
      end
    end
    chk("b2b_gap", second - first, 9);
    chk("b2b_bcd", bcd_out, 12'h042);
    @(negedge clk) load = 1'b0;
    repeat (12) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
